// File: rtl/srl_fifo_stream.sv
`default_nettype none
// ============================================================================
// Module   : srl_fifo_stream
// Purpose  : Valid/ready stream FIFO on an unreset shift array. The array
//            maps onto SRL primitives. Define SRL_FIFO_STREAM_OREG_EN to add
//            a registered output stage, which gives DEPTH+1 capacity.
// Revision : 1.0 - initial release
// ============================================================================
module srl_fifo_stream #(
    parameter int WIDTH      = 18,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      i_tdata,
    input  logic                  i_tvalid,
    output logic                  i_tready,
    output logic [WIDTH-1:0]      o_tdata,
    output logic                  o_tvalid,
    input  logic                  o_tready,
    output logic [DEPTH_LOG2:0]   occupied,
    output logic [DEPTH_LOG2:0]   space
);

    localparam int                    C_DEPTH     = 2**DEPTH_LOG2;
    localparam int                    C_CW        = DEPTH_LOG2 + 1;
    localparam logic [C_CW-1:0]       C_DEPTH_CNT = C_CW'(C_DEPTH);
    localparam logic [C_CW-1:0]       C_ONE       = C_CW'(1);
    localparam logic [DEPTH_LOG2-1:0] C_ADDR_ONE  = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem_q [C_DEPTH];
    logic [C_CW-1:0]       arr_cnt_q;
    logic [C_CW-1:0]       arr_cnt_d;
    logic [DEPTH_LOG2-1:0] w_rd_addr;
    logic [WIDTH-1:0]      w_arr_data;
    logic                  w_arr_full;
    logic                  w_arr_empty;
    logic                  w_push;
    logic                  w_arr_pop;
    logic                  w_shift;

    assign w_arr_full  = (arr_cnt_q == C_DEPTH_CNT);
    assign w_arr_empty = (arr_cnt_q == '0);
    assign w_push      = i_tvalid & i_tready;
    assign w_shift     = w_push & ~clear;

    // The oldest word sits at index cnt-1. An empty array wraps this to the
    // top entry, which is harmless because nobody reads it then.
    assign w_rd_addr  = arr_cnt_q[DEPTH_LOG2-1:0] - C_ADDR_ONE;
    assign w_arr_data = mem_q[w_rd_addr];

    // No reset on the array, so synthesis can map it onto SRL primitives.
    always_ff @(posedge clk) begin
        if (w_shift) begin
            mem_q[0] <= i_tdata;
            for (int k = 1; k < C_DEPTH; k++) begin
                mem_q[k] <= mem_q[k-1];
            end
        end
    end

    always_comb begin
        arr_cnt_d = arr_cnt_q;
        if (clear) begin
            arr_cnt_d = '0;
        end else begin
            case ({w_push, w_arr_pop})
                2'b10:   arr_cnt_d = arr_cnt_q + C_ONE;
                2'b01:   arr_cnt_d = arr_cnt_q - C_ONE;
                default: arr_cnt_d = arr_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_cnt_q <= '0;
        end else begin
            arr_cnt_q <= arr_cnt_d;
        end
    end

`ifdef SRL_FIFO_STREAM_OREG_EN
    logic [WIDTH-1:0] oreg_q;
    logic             oreg_vld_q;
    logic             w_load;

    // The stage refills whenever it is empty or being drained.
    assign w_load    = (~oreg_vld_q | o_tready) & ~w_arr_empty;
    assign w_arr_pop = w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_q     <= '0;
            oreg_vld_q <= 1'b0;
        end else if (clear) begin
            oreg_vld_q <= 1'b0;
        end else if (w_load) begin
            oreg_q     <= w_arr_data;
            oreg_vld_q <= 1'b1;
        end else if (o_tready) begin
            oreg_vld_q <= 1'b0;
        end
    end

    // A full array behind an empty stage still accepts data, because the
    // load pops one entry in that same cycle.
    assign i_tready = ~(w_arr_full & oreg_vld_q);
    assign o_tvalid = oreg_vld_q;
    assign o_tdata  = oreg_q;
    assign occupied = arr_cnt_q + C_CW'(oreg_vld_q);
    assign space    = C_DEPTH_CNT + C_ONE - occupied;
`else
    assign w_arr_pop = o_tvalid & o_tready;
    assign i_tready  = ~w_arr_full;
    assign o_tvalid  = ~w_arr_empty;
    assign o_tdata   = w_arr_data;
    assign occupied  = arr_cnt_q;
    assign space     = C_DEPTH_CNT - arr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_srl_fifo_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_srl_fifo_stream
// Purpose  : Directed self-checking bench for srl_fifo_stream (default build)
// Revision : 1.0 - initial release
// ============================================================================
module tb_srl_fifo_stream;

    localparam int WIDTH      = 18;
    localparam int DEPTH_LOG2 = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic [WIDTH-1:0]  i_tdata;
    logic              i_tvalid;
    logic              i_tready;
    logic [WIDTH-1:0]  o_tdata;
    logic              o_tvalid;
    logic              o_tready;
    logic [DEPTH_LOG2:0] occupied;
    logic [DEPTH_LOG2:0] space;

    int n_checks = 0;
    int n_errors = 0;

    srl_fifo_stream #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .occupied (occupied),
        .space    (space)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        i_tdata  = '0;
        i_tvalid = 1'b0;
        o_tready = 1'b0;
        #12;
        chk("rst_tvalid",   32'(o_tvalid), 32'd0);
        chk("rst_tready",   32'(i_tready), 32'd1);
        chk("rst_occupied", 32'(occupied), 32'd0);
        chk("rst_space",    32'(space),    32'd16);
        rst_n = 1'b1;
        tick();

        // Fill the FIFO with the consumer stalled.
        for (int i = 1; i <= 16; i++) begin
            i_tdata  = 18'(i);
            i_tvalid = 1'b1;
            tick();
            if (i == 1) begin
                chk("fill_first_tvalid", 32'(o_tvalid), 32'd1);
                chk("fill_first_tdata",  32'(o_tdata),  32'h1);
            end
        end
        chk("full_tready",   32'(i_tready), 32'd0);
        chk("full_occupied", 32'(occupied), 32'd16);
        chk("full_space",    32'(space),    32'd0);
        i_tdata = 18'h3FFFF;
        tick();
        chk("full_ignore_occ",  32'(occupied), 32'd16);
        chk("full_ignore_head", 32'(o_tdata),  32'h1);
        i_tvalid = 1'b0;

        // Drain the full FIFO.
        o_tready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_tvalid", 32'(o_tvalid), 32'd1);
            chk("drain_tdata",  32'(o_tdata),  32'(i));
            tick();
        end
        chk("drained_tvalid",   32'(o_tvalid), 32'd0);
        chk("drained_occupied", 32'(occupied), 32'd0);
        chk("drained_tready",   32'(i_tready), 32'd1);
        o_tready = 1'b0;

        // Preload 5 words, then push and pop every cycle for 100 cycles.
        for (int i = 0; i < 5; i++) begin
            i_tdata  = 18'(32'h100 + i);
            i_tvalid = 1'b1;
            tick();
        end
        chk("stream_pre_occ", 32'(occupied), 32'd5);
        o_tready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            i_tdata = 18'(32'h105 + k);
            chk("stream_tvalid", 32'(o_tvalid), 32'd1);
            chk("stream_tdata",  32'(o_tdata),  32'h100 + 32'(k));
            tick();
            chk("stream_occ", 32'(occupied), 32'd5);
        end
        i_tvalid = 1'b0;
        for (int k = 100; k < 105; k++) begin
            chk("stream_tail", 32'(o_tdata), 32'h100 + 32'(k));
            tick();
        end
        chk("stream_end_occ", 32'(occupied), 32'd0);
        o_tready = 1'b0;

        // A single word from empty, with no same-cycle bypass.
        i_tdata  = 18'h2AAAA;
        i_tvalid = 1'b1;
        #1;
        chk("single_no_bypass", 32'(o_tvalid), 32'd0);
        tick();
        i_tvalid = 1'b0;
        chk("single_tvalid", 32'(o_tvalid), 32'd1);
        chk("single_tdata",  32'(o_tdata),  32'h2AAAA);
        o_tready = 1'b1;
        tick();
        o_tready = 1'b0;
        chk("single_empty", 32'(occupied), 32'd0);

        // A clear at occupancy 7 drops the word offered in the same cycle.
        for (int i = 0; i < 7; i++) begin
            i_tdata  = 18'(32'h300 + i);
            i_tvalid = 1'b1;
            tick();
        end
        chk("clr_pre_occ", 32'(occupied), 32'd7);
        clear   = 1'b1;
        i_tdata = 18'h12345;
        tick();
        clear    = 1'b0;
        i_tvalid = 1'b0;
        chk("clr_occ",    32'(occupied), 32'd0);
        chk("clr_tvalid", 32'(o_tvalid), 32'd0);
        chk("clr_tready", 32'(i_tready), 32'd1);
        chk("clr_space",  32'(space),    32'd16);
        i_tdata  = 18'h00055;
        i_tvalid = 1'b1;
        tick();
        i_tvalid = 1'b0;
        chk("clr_next_occ",  32'(occupied), 32'd1);
        chk("clr_next_data", 32'(o_tdata),  32'h55);
        o_tready = 1'b1;
        tick();
        o_tready = 1'b0;

        // An asynchronous reset between clock edges at occupancy 9.
        for (int i = 0; i < 9; i++) begin
            i_tdata  = 18'(32'h400 + i);
            i_tvalid = 1'b1;
            tick();
        end
        i_tvalid = 1'b0;
        chk("arst_pre_occ", 32'(occupied), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", 32'(o_tvalid), 32'd0);
        chk("arst_occ",    32'(occupied), 32'd0);
        chk("arst_tready", 32'(i_tready), 32'd1);
        chk("arst_space",  32'(space),    32'd16);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        i_tdata  = 18'h00077;
        i_tvalid = 1'b1;
        tick();
        i_tvalid = 1'b0;
        chk("arst_new_tvalid", 32'(o_tvalid), 32'd1);
        chk("arst_new_tdata",  32'(o_tdata),  32'h77);
        chk("arst_new_occ",    32'(occupied), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
